mant_addsub_pipe: RTL

Parametrised, two-stage pipelined carry-lookahead mantissa adder/subtractor for the IEEE 754 datapath. It sits after exponent alignment and before normalisation. It takes two aligned unsigned significands plus an op bit, and returns the sum or the magnitude of the difference, together with carry, sign, zero and (optionally) leading-zero flags. Valid/ready handshakes on both sides allow back-to-back operands at one result per cycle under backpressure.

---
 rtl/mant_addsub_pkg.sv | 13 +
 rtl/cla_group.sv | 43 ++++
 rtl/mant_addsub_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mant_addsub_pkg.sv
// Shared types and helpers for the pipelined mantissa adder/subtractor.
package mant_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int unsigned lzc_width(int unsigned w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead adder slice: sum, carry-out and group generate/propagate.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             c_i,
  output logic [GROUP-1:0] sum_o,
  output logic             c_o,
  output logic             g_o,
  output logic             p_o
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP:0]   carry;
  logic             grp_g;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  always_comb begin
    carry    = '0;
    carry[0] = c_i;
    for (int k = 0; k < GROUP; k++) begin
      carry[k+1] = gen[k] | (prop[k] & carry[k]);
    end
  end

  // Kept apart from the carry chain so G/P never depend on c_i.
  always_comb begin
    grp_g = 1'b0;
    for (int k = 0; k < GROUP; k++) begin
      grp_g = gen[k] | (prop[k] & grp_g);
    end
  end

  assign sum_o = prop ^ carry[GROUP-1:0];
  assign c_o   = carry[GROUP];
  assign g_o   = grp_g;
  assign p_o   = &prop;

endmodule

// File: rtl/mant_addsub_pipe.sv
// Two-stage pipelined CLA mantissa adder/subtractor with valid/ready flow control.
// Define MANT_ADDSUB_LZC_EN to build the stage-2 leading-zero counter; otherwise out_lzc is 0.
module mant_addsub_pipe
  import mant_addsub_pkg::*;
#(
  parameter int unsigned W     = 24,
  parameter int unsigned GROUP = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_op,
  input  logic [W-1:0]            in_a,
  input  logic [W-1:0]            in_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W:0]              out_sum,
  output logic                    out_neg,
  output logic                    out_zero,
  output logic [lzc_width(W)-1:0] out_lzc,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned NG = H / GROUP;

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_ready, s2_ready, s1_load, s2_load;

  assign s2_ready = ~s2_valid_q | out_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign in_ready = s1_ready & ~rst;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & s2_ready;

  // Stage 1: subtract as a + ~b + 1, low half through the group lookahead
  op_t           op_in;
  logic          cin;
  logic [W-1:0]  b_eff;
  logic [H-1:0]  lo_sum;
  logic [NG-1:0] lo_g, lo_p, lo_cout;
  logic [NG:0]   lo_c;

  assign op_in = op_t'(in_op);
  assign cin   = (op_in == OP_SUB);
  assign b_eff = cin ? ~in_b : in_b;

  always_comb begin
    lo_c    = '0;
    lo_c[0] = cin;
    for (int g = 0; g < NG; g++) lo_c[g+1] = lo_g[g] | (lo_p[g] & lo_c[g]);
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_lo
    cla_group #(.GROUP(GROUP)) u_cla (
      .a_i   (in_a[gi*GROUP +: GROUP]),
      .b_i   (b_eff[gi*GROUP +: GROUP]),
      .c_i   (lo_c[gi]),
      .sum_o (lo_sum[gi*GROUP +: GROUP]),
      .c_o   (lo_cout[gi]),
      .g_o   (lo_g[gi]),
      .p_o   (lo_p[gi])
    );
  end

  logic [H-1:0]     lo_sum_q, lo_sum_d, a_hi_q, a_hi_d, b_hi_q, b_hi_d;
  logic             lo_c_q, lo_c_d;
  op_t              op_q, op_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // Stage 2: upper half, then sign-magnitude fix-up for subtract
  logic [H-1:0]  hi_sum;
  logic [NG-1:0] hi_g, hi_p, hi_cout;
  logic [NG:0]   hi_c;
  logic [W-1:0]  raw, raw_neg;
  logic          carry;
  logic [W:0]    res_sum;
  logic          res_neg;

  always_comb begin
    hi_c    = '0;
    hi_c[0] = lo_c_q;
    for (int g = 0; g < NG; g++) hi_c[g+1] = hi_g[g] | (hi_p[g] & hi_c[g]);
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_hi
    cla_group #(.GROUP(GROUP)) u_cla (
      .a_i   (a_hi_q[gi*GROUP +: GROUP]),
      .b_i   (b_hi_q[gi*GROUP +: GROUP]),
      .c_i   (hi_c[gi]),
      .sum_o (hi_sum[gi*GROUP +: GROUP]),
      .c_o   (hi_cout[gi]),
      .g_o   (hi_g[gi]),
      .p_o   (hi_p[gi])
    );
  end

  // Per-group carry-outs duplicate the lookahead carries above.
  logic unused_cout;
  assign unused_cout = ^{lo_cout, hi_cout};

  assign raw     = {hi_sum, lo_sum_q};
  assign carry   = hi_c[NG];
  assign raw_neg = ~raw + {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    res_sum = {1'b0, raw};
    res_neg = 1'b0;
    unique case (op_q)
      OP_ADD: res_sum = {carry, raw};
      OP_SUB: begin
        if (!carry) begin
          res_sum = {1'b0, raw_neg};
          res_neg = 1'b1;
        end
      end
    endcase
  end

  logic [W:0]       sum_q, sum_d;
  logic             neg_q, neg_d, zero_q, zero_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  always_comb begin
    s1_valid_d = s1_load | (s1_valid_q & ~s2_ready);
    lo_sum_d   = lo_sum_q;
    lo_c_d     = lo_c_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    op_d       = op_q;
    tag1_d     = tag1_q;
    if (s1_load) begin
      lo_sum_d = lo_sum;
      lo_c_d   = lo_c[NG];
      a_hi_d   = in_a[W-1:H];
      b_hi_d   = b_eff[W-1:H];
      op_d     = op_in;
      tag1_d   = in_tag;
    end
    s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
    sum_d      = sum_q;
    neg_d      = neg_q;
    zero_d     = zero_q;
    tag2_d     = tag2_q;
    if (s2_load) begin
      sum_d  = res_sum;
      neg_d  = res_neg;
      zero_d = (res_sum == '0);
      tag2_d = tag1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      lo_sum_q   <= '0;
      lo_c_q     <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      op_q       <= OP_ADD;
      tag1_q     <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      neg_q      <= 1'b0;
      zero_q     <= 1'b0;
      tag2_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      lo_sum_q   <= lo_sum_d;
      lo_c_q     <= lo_c_d;
      a_hi_q     <= a_hi_d;
      b_hi_q     <= b_hi_d;
      op_q       <= op_d;
      tag1_q     <= tag1_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      neg_q      <= neg_d;
      zero_q     <= zero_d;
      tag2_q     <= tag2_d;
    end
  end

`ifdef MANT_ADDSUB_LZC_EN
  localparam int unsigned LzcW = lzc_width(W);
  logic [LzcW-1:0] res_lzc, lzc_q, lzc_d;

  // Highest set bit wins since the scan runs upward.
  always_comb begin
    res_lzc = LzcW'(W + 1);
    for (int i = 0; i <= int'(W); i++) begin
      if (res_sum[i]) res_lzc = LzcW'(W - i);
    end
  end

  always_comb begin
    lzc_d = lzc_q;
    if (s2_load) lzc_d = res_lzc;
  end

  always_ff @(posedge clk) begin
    if (rst) lzc_q <= '0;
    else     lzc_q <= lzc_d;
  end

  assign out_lzc = lzc_q;
`else
  assign out_lzc = '0;
`endif

  assign out_valid = s2_valid_q;
  assign out_sum   = sum_q;
  assign out_neg   = neg_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag2_q;

endmodule
